pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Top-level game sequencer for the pong design. Sequences serve, rally, scoring, pause and game-over, gates ball motion, and selects whether each paddle is player- or AI-driven. Sits between the input buttons, the ball mover and both paddle movers; scores feed the score display.

## Interface
Parameters:
- DISP_COLS, 800, display width in pixels; sets the miss boundary.
- MISS_MARGIN, 8, a ball column within this many pixels of either edge counts as a miss.
- WIN_SCORE, 7, score that ends the game (1..15).
- SERVE_FRAMES, 60, frames the ball is held before a serve.
- POINT_FRAMES, 90, frames the ball is held after a point.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- start_btn  in  1  level, already synchronized and debounced
- two_player  in  1  1 = right paddle player-driven
- ball_center_col  in  12  current ball column
- ball_run  out  1  1 = ball mover advances
- ball_load  out  1  one-cycle pulse: ball mover recenters the ball
- serve_dir  out  1  0 = serve toward left, 1 = toward right
- score_l, score_r  out  4 each  scores
- winner  out  2  00 none, 01 left, 10 right
- state  out  3  current state encoding
- l_paddle_ai, r_paddle_ai  out  1 each  1 = paddle driven by its AI mover

## Operation
- start_rise = start_btn high this cycle and low the previous cycle. The previous-value register resets to 1, so a button held through reset makes no edge.
- States and encodings: IDLE 0, SERVE 1, PLAY 2, POINT 3, PAUSE 4, OVER 5.
- IDLE: ball_run 0. On start_rise: clear scores and winner, set serve_dir 0, latch two_player into mode_2p, pulse ball_load, clear frame counter, go to SERVE.
- SERVE: ball_run 0. Count frame_tick. On the tick that makes the count reach SERVE_FRAMES, go to PLAY.
- PLAY: ball_run 1. Miss checks run every cycle:
  - Left miss (col <= MISS_MARGIN): score_r + 1, serve_dir 0.
  - Right miss (col >= DISP_COLS-1-MISS_MARGIN): score_l + 1, serve_dir 1.
  - Left miss wins if both are true.
  - After a miss: if the new score equals WIN_SCORE, set winner and go to OVER. Otherwise clear the counter and go to POINT.
  - start_rise in PLAY goes to PAUSE. A miss in the same cycle takes priority.
- PAUSE: ball_run 0; scores and counter hold. start_rise returns to PLAY.
- POINT: ball_run 0. On the tick that makes the count reach POINT_FRAMES, pulse ball_load and go to SERVE with the counter cleared.
- OVER: ball_run 0; scores and winner hold. start_rise acts exactly as in IDLE (new game).
- Paddle select outside IDLE: l_paddle_ai = 0, r_paddle_ai = ~mode_2p.
- Paddle select in IDLE: both are 1 with the macro defined, both 0 without.
- Scores never exceed WIN_SCORE and never wrap. The frame counter is 8 bits and is cleared on every state entry.

## Timing
- All outputs are registered and update on the clk edge after the causing input.
- Reset values: state IDLE, ball_run 0, ball_load 0, serve_dir 0, both scores 0, winner 00, mode_2p 0. Paddle-select outputs take their IDLE values.
- rst dominates every other input in any state. Reset mid-rally returns to IDLE within one cycle, with ball_run low on the next edge.
- ball_load is exactly one cycle wide. It is asserted in the same cycle the state register shows SERVE.
- State changes take effect at the edge after the miss, tick or start_rise.
- A miss is registered once: leaving PLAY blocks re-scoring while the ball sits at the edge.
- frame_tick is ignored in PLAY, PAUSE, IDLE and OVER.

## Configuration
- PONG_ATTRACT_EN defined:
  - IDLE is a demo. ball_run is 1 and both paddles use AI.
  - A miss in IDLE pulses ball_load and toggles serve_dir only. Scores are unchanged.
  - start_rise leaves the demo as specified in Operation.
- PONG_ATTRACT_EN undefined: IDLE holds ball_run 0 and both paddle-select outputs 0.

## Test plan
- Reset, then start_btn high for 3 cycles -> one ball_load pulse; state 1. After 60 frame_ticks, state 2 and ball_run 1.
- In PLAY, drive col = 5 -> next cycle score_r = 1, serve_dir 0, state 3. After 90 ticks, ball_load pulses and state is 1.
- Left score at 6, drive col = 791 with DISP_COLS 800 -> score_l 7, winner 01, state 5. A further miss leaves scores unchanged.
- start_rise in PLAY -> state 4, ball_run 0. A second start_rise -> state 2, scores preserved.
- rst mid-rally (ball_run 1, score 3-2) -> next cycle state 0, scores 0, ball_run 0. Holding start_btn through reset produces no game start.
- With PONG_ATTRACT_EN: IDLE shows ball_run 1 and both AI selects 1. A miss in IDLE pulses ball_load and leaves scores at 0.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve, rally, scoring, pause and game-over; gates ball motion and paddle AI select.
// Define PONG_ATTRACT_EN to run IDLE as an AI-vs-AI attract demo.
module pong_game_ctrl #(
  parameter int unsigned DISP_COLS    = 800,
  parameter int unsigned MISS_MARGIN  = 8,
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start_btn,
  input  logic        two_player,
  input  logic [11:0] ball_center_col,
  output logic        ball_run,
  output logic        ball_load,
  output logic        serve_dir,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic [1:0]  winner,
  output logic [2:0]  state,
  output logic        l_paddle_ai,
  output logic        r_paddle_ai
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned COL_W   = 12;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  localparam logic [COL_W-1:0]   LEFT_EDGE  = COL_W'(MISS_MARGIN);
  localparam logic [COL_W-1:0]   RIGHT_EDGE = COL_W'(DISP_COLS - 1 - MISS_MARGIN);
  localparam logic [CNT_W-1:0]   SERVE_LIM  = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0]   POINT_LIM  = CNT_W'(POINT_FRAMES);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

`ifdef PONG_ATTRACT_EN
  localparam logic IDLE_AI  = 1'b1;
  localparam logic IDLE_RUN = 1'b1;
`else
  localparam logic IDLE_AI  = 1'b0;
  localparam logic IDLE_RUN = 1'b0;
`endif

  logic [2:0]         state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [SCORE_W-1:0] score_l_q,   score_l_d;
  logic [SCORE_W-1:0] score_r_q,   score_r_d;
  logic [1:0]         winner_q,    winner_d;
  logic               serve_dir_q, serve_dir_d;
  logic               mode_2p_q,   mode_2p_d;
  logic               ball_load_q, ball_load_d;
  logic               ball_run_q,  ball_run_d;
  logic               l_ai_q,      l_ai_d;
  logic               r_ai_q,      r_ai_d;
  logic               start_prev_q;

  logic start_rise;
  logic miss_l;
  logic miss_r;
  logic new_game;

  // Previous-button register resets high so a button held through reset is not an edge.
  assign start_rise = start_btn & ~start_prev_q;
  assign miss_l     = (ball_center_col <= LEFT_EDGE);
  assign miss_r     = (ball_center_col >= RIGHT_EDGE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      score_l_q    <= '0;
      score_r_q    <= '0;
      winner_q     <= 2'b00;
      serve_dir_q  <= 1'b0;
      mode_2p_q    <= 1'b0;
      ball_load_q  <= 1'b0;
      ball_run_q   <= 1'b0;
      l_ai_q       <= IDLE_AI;
      r_ai_q       <= IDLE_AI;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      winner_q     <= winner_d;
      serve_dir_q  <= serve_dir_d;
      mode_2p_q    <= mode_2p_d;
      ball_load_q  <= ball_load_d;
      ball_run_q   <= ball_run_d;
      l_ai_q       <= l_ai_d;
      r_ai_q       <= r_ai_d;
      start_prev_q <= start_btn;
    end
  end

  // Next-state and next-output logic; outputs are derived from the next state so they align with it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    winner_d    = winner_q;
    serve_dir_d = serve_dir_q;
    mode_2p_d   = mode_2p_q;
    ball_load_d = 1'b0;
    new_game    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          new_game = 1'b1;
        end
`ifdef PONG_ATTRACT_EN
        // Demo rally: recenter once per miss, the pending load blocks a repeat while the ball sits at the edge.
        else if ((miss_l || miss_r) && !ball_load_q) begin
          ball_load_d = 1'b1;
          serve_dir_d = ~serve_dir_q;
        end
`endif
      end
      S_SERVE: begin
        if (frame_tick) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == SERVE_LIM) begin
            state_d = S_PLAY;
          end
        end
      end
      S_PLAY: begin
        if (miss_l) begin
          if (score_r_q < WIN_VAL) begin
            score_r_d = score_r_q + SCORE_W'(1);
          end
          serve_dir_d = 1'b0;
          if (score_r_d == WIN_VAL) begin
            winner_d = 2'b10;
            state_d  = S_OVER;
          end else begin
            state_d = S_POINT;
          end
        end else if (miss_r) begin
          if (score_l_q < WIN_VAL) begin
            score_l_d = score_l_q + SCORE_W'(1);
          end
          serve_dir_d = 1'b1;
          if (score_l_d == WIN_VAL) begin
            winner_d = 2'b01;
            state_d  = S_OVER;
          end else begin
            state_d = S_POINT;
          end
        end else if (start_rise) begin
          state_d = S_PAUSE;
        end
      end
      S_POINT: begin
        if (frame_tick) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == POINT_LIM) begin
            ball_load_d = 1'b1;
            state_d     = S_SERVE;
          end
        end
      end
      S_PAUSE: begin
        if (start_rise) begin
          state_d = S_PLAY;
        end
      end
      S_OVER: begin
        if (start_rise) begin
          new_game = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (new_game) begin
      score_l_d   = '0;
      score_r_d   = '0;
      winner_d    = 2'b00;
      serve_dir_d = 1'b0;
      mode_2p_d   = two_player;
      ball_load_d = 1'b1;
      state_d     = S_SERVE;
    end

    // Every state entry restarts the frame count.
    if (state_d != state_q) begin
      cnt_d = '0;
    end

    ball_run_d = (state_d == S_PLAY) || ((state_d == S_IDLE) && IDLE_RUN);
    if (state_d == S_IDLE) begin
      l_ai_d = IDLE_AI;
      r_ai_d = IDLE_AI;
    end else begin
      l_ai_d = 1'b0;
      r_ai_d = ~mode_2p_d;
    end
  end

  assign state       = state_q;
  assign ball_run    = ball_run_q;
  assign ball_load   = ball_load_q;
  assign serve_dir   = serve_dir_q;
  assign score_l     = score_l_q;
  assign score_r     = score_r_q;
  assign winner      = winner_q;
  assign l_paddle_ai = l_ai_q;
  assign r_paddle_ai = r_ai_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed game scenarios against a countdown-based game model.
module tb_pong_game_ctrl;

  localparam int RIGHT_COL = 791;  // 800 - 1 - 8
  localparam int LEFT_COL  = 8;
  localparam int WIN       = 7;
  localparam int SERVE_N   = 60;
  localparam int POINT_N   = 90;
`ifdef PONG_ATTRACT_EN
  localparam int ATTRACT = 1;
`else
  localparam int ATTRACT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        start_btn = 1'b0;
  logic        two_player = 1'b0;
  logic [11:0] ball_center_col = 12'd400;
  logic        ball_run, ball_load, serve_dir;
  logic [3:0]  score_l, score_r;
  logic [1:0]  winner;
  logic [2:0]  state;
  logic        l_paddle_ai, r_paddle_ai;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .frame_tick      (frame_tick),
    .start_btn       (start_btn),
    .two_player      (two_player),
    .ball_center_col (ball_center_col),
    .ball_run        (ball_run),
    .ball_load       (ball_load),
    .serve_dir       (serve_dir),
    .score_l         (score_l),
    .score_r         (score_r),
    .winner          (winner),
    .state           (state),
    .l_paddle_ai     (l_paddle_ai),
    .r_paddle_ai     (r_paddle_ai)
  );

  int checks = 0;
  int passes = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s: got %0d, want %0d", name, got, want);
  endtask

  // Game model: phase numbers follow the published state codes; holds count down in frames.
  int m_phase = 0, m_hold = 0, m_sl = 0, m_sr = 0, m_win = 0;
  int m_dir = 0, m_2p = 0, m_load = 0, m_run = 0, prev_load = 0;
  bit m_prev = 1'b1, rise, lmiss, rmiss;

  always @(posedge clk) begin
    rise  = start_btn && !m_prev;
    lmiss = ball_center_col <= LEFT_COL;
    rmiss = ball_center_col >= RIGHT_COL;
    prev_load = m_load;
    m_load = 0;
    if (rst) begin
      m_phase = 0; m_sl = 0; m_sr = 0; m_win = 0; m_dir = 0; m_2p = 0;
      m_prev = 1'b1;
      m_run = 0;
    end else begin
      m_prev = start_btn;
      if ((m_phase == 0 || m_phase == 5) && rise) begin
        m_sl = 0; m_sr = 0; m_win = 0; m_dir = 0; m_2p = two_player;
        m_load = 1; m_phase = 1; m_hold = SERVE_N;
      end else if (m_phase == 0) begin
        if (ATTRACT == 1 && (lmiss || rmiss) && prev_load == 0) begin
          m_load = 1; m_dir = 1 - m_dir;
        end
      end else if (m_phase == 1) begin
        if (frame_tick) begin
          m_hold--;
          if (m_hold == 0) m_phase = 2;
        end
      end else if (m_phase == 2) begin
        if (lmiss) begin
          m_sr++; m_dir = 0;
          if (m_sr == WIN) begin m_win = 2; m_phase = 5; end
          else begin m_phase = 3; m_hold = POINT_N; end
        end else if (rmiss) begin
          m_sl++; m_dir = 1;
          if (m_sl == WIN) begin m_win = 1; m_phase = 5; end
          else begin m_phase = 3; m_hold = POINT_N; end
        end else if (rise) begin
          m_phase = 4;
        end
      end else if (m_phase == 3) begin
        if (frame_tick) begin
          m_hold--;
          if (m_hold == 0) begin m_load = 1; m_phase = 1; m_hold = SERVE_N; end
        end
      end else if (m_phase == 4) begin
        if (rise) m_phase = 2;
      end
      m_run = (m_phase == 2 || (m_phase == 0 && ATTRACT == 1)) ? 1 : 0;
    end
  end

  // Cycle-by-cycle comparison against the model, just after each active edge.
  always begin
    @(posedge clk);
    #1;
    if (chk_en) begin
      check("cyc_state", int'(state), m_phase);
      check("cyc_ball_run", int'(ball_run), m_run);
      check("cyc_ball_load", int'(ball_load), m_load);
      check("cyc_serve_dir", int'(serve_dir), m_dir);
      check("cyc_score_l", int'(score_l), m_sl);
      check("cyc_score_r", int'(score_r), m_sr);
      check("cyc_winner", int'(winner), m_win);
      check("cyc_l_ai", int'(l_paddle_ai), (m_phase == 0) ? ATTRACT : 0);
      check("cyc_r_ai", int'(r_paddle_ai), (m_phase == 0) ? ATTRACT : (m_2p == 0 ? 1 : 0));
    end
  end

  task automatic tick2();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  // One miss at column c, then run the point hold and serve hold back into PLAY.
  task automatic score_point(input int c);
    ball_center_col = 12'(c);
    @(negedge clk);
    ball_center_col = 12'd400;
    repeat (POINT_N) tick2();
    repeat (SERVE_N) tick2();
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_state", int'(state), 0);
    check("rst_ball_run", int'(ball_run), 0);
    check("rst_scores", int'(score_l) + int'(score_r), 0);
    check("rst_winner", int'(winner), 0);
    rst = 1'b0;
    @(negedge clk);

    start_btn = 1'b1;
    @(negedge clk);
    check("start_load", int'(ball_load), 1);
    check("start_state", int'(state), 1);
    check("start_r_ai_1p", int'(r_paddle_ai), 1);
    @(negedge clk);
    check("load_one_cycle", int'(ball_load), 0);
    @(negedge clk);
    start_btn = 1'b0;

    repeat (SERVE_N - 1) tick2();
    check("serve_59_state", int'(state), 1);
    check("serve_59_run", int'(ball_run), 0);
    tick2();
    check("serve_60_state", int'(state), 2);
    check("serve_60_run", int'(ball_run), 1);

    ball_center_col = 12'd5;
    @(negedge clk);
    check("lmiss_score_r", int'(score_r), 1);
    check("lmiss_dir", int'(serve_dir), 0);
    check("lmiss_state", int'(state), 3);
    @(negedge clk);
    check("lmiss_once", int'(score_r), 1);
    ball_center_col = 12'd400;
    repeat (POINT_N - 1) tick2();
    check("point_89_state", int'(state), 3);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check("point_90_load", int'(ball_load), 1);
    check("point_90_state", int'(state), 1);
    @(negedge clk);
    repeat (SERVE_N) tick2();
    check("replay_state", int'(state), 2);

    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    check("pause_state", int'(state), 4);
    check("pause_run", int'(ball_run), 0);
    repeat (3) tick2();
    check("pause_hold", int'(state), 4);
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    check("resume_state", int'(state), 2);
    check("resume_score_r", int'(score_r), 1);

    score_point(RIGHT_COL);
    check("rmiss_dir", int'(serve_dir), 1);
    check("rmiss_score_l", int'(score_l), 1);
    repeat (5) score_point(RIGHT_COL);
    check("six_score_l", int'(score_l), 6);
    ball_center_col = 12'(RIGHT_COL);
    @(negedge clk);
    check("win_score_l", int'(score_l), 7);
    check("win_winner", int'(winner), 1);
    check("win_state", int'(state), 5);
    check("win_run", int'(ball_run), 0);
    @(negedge clk);
    ball_center_col = 12'd5;
    @(negedge clk);
    ball_center_col = 12'd400;
    tick2();
    check("over_score_l", int'(score_l), 7);
    check("over_score_r", int'(score_r), 1);
    check("over_state", int'(state), 5);

    two_player = 1'b1;
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    check("newgame_state", int'(state), 1);
    check("newgame_scores", int'(score_l) + int'(score_r), 0);
    check("newgame_winner", int'(winner), 0);
    check("newgame_r_ai_2p", int'(r_paddle_ai), 0);
    repeat (SERVE_N) tick2();
    two_player = 1'b0;
    check("g2_play", int'(state), 2);
    repeat (3) score_point(RIGHT_COL);
    repeat (2) score_point(5);
    check("mid_score_l", int'(score_l), 3);
    check("mid_score_r", int'(score_r), 2);
    check("mid_run", int'(ball_run), 1);
    check("mid_r_ai_latched", int'(r_paddle_ai), 0);

    rst = 1'b1;
    start_btn = 1'b1;
    @(negedge clk);
    check("midrst_state", int'(state), 0);
    check("midrst_scores", int'(score_l) + int'(score_r), 0);
    check("midrst_run", int'(ball_run), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("held_btn_state", int'(state), 0);
    check("held_btn_load", int'(ball_load), 0);
    start_btn = 1'b0;
    @(negedge clk);
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    check("restart_state", int'(state), 1);
    @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
